icache_data_array: RTL

- Parametrised successor to the instruction-cache data RAM: a WAYS-way set-associative data array with a registered read port.
- Adds a line-fill engine that writes a whole cache line, one word per beat, from the memory-refill path into a latched way.
- Adds a single-word store port with byte enables, and write-first forwarding.
- Sits between the I-cache controller (tag compare, way select) and the refill bus. Ways at index LOW_WAYS and above form the high partition.

---
 rtl/icache_data_array_pkg.sv | 13 +
 rtl/icache_way_ram.sv | 43 ++++
 rtl/icache_data_array.sv | 124 ++++++++++++
 3 files changed

// File: rtl/icache_data_array_pkg.sv
// Shared widths and fill-engine state encoding for the instruction-cache data array.
package icache_data_array_pkg;

  localparam int I_INDEX_WIDTH = 6;
  localparam int I_WO_WIDTH    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: byte-enabled write port, registered read port, write-first forwarding.
module icache_way_ram #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rd_data
);
  localparam int NB = DW / 8;

  // Contents are not reset; the initialiser only gives simulation a known start.
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  logic [DW-1:0] fwd;

  always_comb begin
    fwd = mem[rd_addr];
    for (int b = 0; b < NB; b++) begin
      if (be[b]) fwd[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we && be[b]) mem[wr_addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (we && (wr_addr == rd_addr)) ? fwd : mem[rd_addr];
    end
  end

endmodule

// File: rtl/icache_data_array.sv
// WAYS-way I-cache data array with single-word stores and a line-fill engine from the refill bus.
module icache_data_array
  import icache_data_array_pkg::*;
#(
  parameter int DW       = 32,
  parameter int WAYS     = 4,
  parameter int LOW_WAYS = 2,
  parameter int INDEX_W  = I_INDEX_WIDTH,
  parameter int WO_W     = I_WO_WIDTH,
  parameter int WAY_W    = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [WO_W-1:0]     rd_offset,
  output logic [WAYS*DW-1:0]  rd_data,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [WAY_W-1:0]    wr_way,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [WO_W-1:0]     wr_offset,
  input  logic [DW/8-1:0]     wr_be,
  input  logic [DW-1:0]       wr_data,
  input  logic                fill_start,
  input  logic [WAY_W-1:0]    fill_way,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic                fill_wvalid,
  input  logic [DW-1:0]       fill_wdata,
  output logic                fill_busy,
  output logic                fill_done
);
  localparam int AW = INDEX_W + WO_W;

  fill_state_e        state_q, state_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [WO_W-1:0]    cnt_q, cnt_d;

  logic start_acc, beat, store_ok;
  logic [AW-1:0]   rd_addr, wsel_addr;
  logic [DW/8-1:0] wsel_be;
  logic [DW-1:0]   wsel_data;

  assign start_acc = (state_q == ST_IDLE) && fill_start;
  assign beat      = (state_q == ST_FILL) && fill_wvalid && !rst;
  // Stores lose to the fill engine outright; they are dropped, never queued.
  assign store_ok  = wr_en && (|wr_be) && !rst && (state_q != ST_FILL) && !start_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      way_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d = ST_FILL;
          way_d   = fill_way;
          idx_d   = fill_index;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (fill_wvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_busy = (state_q == ST_FILL);
    fill_done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= rd_en;
  end

  assign rd_addr   = {rd_index, rd_offset};
  assign wsel_addr = beat ? {idx_q, cnt_q} : {wr_index, wr_offset};
  assign wsel_be   = beat ? '1 : wr_be;
  assign wsel_data = beat ? fill_wdata : wr_data;

  // Each way owns its storage, so low-partition slices never see high-way data or writes.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic we_w;
    assign we_w = beat ? (way_q == WAY_W'(w)) : (store_ok && (wr_way == WAY_W'(w)));

    if (w >= LOW_WAYS) begin : g_high
      icache_way_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .we(we_w), .wr_addr(wsel_addr), .be(wsel_be), .wdata(wsel_data),
        .rd_data(rd_data[w*DW +: DW])
      );
    end else begin : g_low
      icache_way_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .we(we_w), .wr_addr(wsel_addr), .be(wsel_be), .wdata(wsel_data),
        .rd_data(rd_data[w*DW +: DW])
      );
    end
  end

endmodule
